// File: rtl/delay_seq_pkg.sv
// Shared definitions for the delay sequencer: step-entry layout, FSM
// encoding, delay-select codes, the default step table and small helpers.
package delay_seq_pkg;

  localparam int ACT_W    = 4;
  localparam int DSEL_W   = 2;
  localparam int STEP_W   = 4;
  localparam int MAX_STEP = 16;
  localparam int TCNT_W   = 24;

  // Delay-length select codes understood by the downstream delay timer.
  localparam logic [DSEL_W-1:0] DSEL_10MS = 2'b00;
  localparam logic [DSEL_W-1:0] DSEL_2S   = 2'b01;

  // One step-table entry: action code, delay select, end-of-sequence mark.
  typedef struct packed {
    logic [ACT_W-1:0]  act;
    logic [DSEL_W-1:0] dsel;
    logic              last;
  } step_entry_t;

  // Full table, always MAX_STEP entries; unused tail entries are ignored.
  typedef step_entry_t [MAX_STEP-1:0] step_table_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic step_entry_t mk_entry(input logic [ACT_W-1:0]  act,
                                           input logic [DSEL_W-1:0] dsel,
                                           input logic              last);
    step_entry_t e;
    e.act  = act;
    e.dsel = dsel;
    e.last = last;
    return e;
  endfunction

  // Default product table: 8 steps, action codes 1..8, delays alternate
  // 10 ms / 2 s starting with 10 ms, last mark on step 7.
  function automatic step_table_t default_table();
    step_table_t t;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      t[i] = mk_entry(4'(i + 1),
                      (i % 2 == 1) ? DSEL_2S : DSEL_10MS,
                      (i == 7) ? 1'b1 : 1'b0);
    end
    return t;
  endfunction

  localparam step_table_t DEFAULT_TABLE = default_table();

  // Saturating increment for the per-step timeout counter.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    logic [TCNT_W-1:0] r;
    if (v == {TCNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 24'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
// master = the side requesting runs and reporting delay elapsed,
// slave  = the sequencer itself.
interface delay_sequencer_if;
  import delay_seq_pkg::*;

  logic              start;
  logic              abort;
  logic              ready_i;
  logic              enable_o;
  logic [DSEL_W-1:0] x_o;
  logic [ACT_W-1:0]  act_o;
  logic [STEP_W-1:0] step_o;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, ready_i,
    input  enable_o, x_o, act_o, step_o, busy, done, err
  );

  modport slave (
    input  start, abort, ready_i,
    output enable_o, x_o, act_o, step_o, busy, done, err
  );

endinterface

// File: rtl/delay_seq_rom.sv
// Step table lookup. Purely combinational so a product can swap the
// table without touching the sequencer. Entry NSTEP-1 always terminates
// the sequence; indices past it read as an empty terminating entry.
module delay_seq_rom
  import delay_seq_pkg::*;
#(
  parameter int          NSTEP = 8,
  parameter step_table_t TABLE = DEFAULT_TABLE
) (
  input  logic [STEP_W-1:0] idx_i,
  output step_entry_t       entry_o
);

  localparam logic [STEP_W-1:0] LAST_IDX = 4'(NSTEP - 1);

  // Select the entry for the current step and force the end mark at the table end.
  always_comb begin
    entry_o = TABLE[idx_i];
    if (idx_i > LAST_IDX) begin
      entry_o = mk_entry(4'd0, DSEL_10MS, 1'b1);
    end else if (idx_i == LAST_IDX) begin
      entry_o.last = 1'b1;
    end else begin
      entry_o.last = TABLE[idx_i].last;
    end
  end

endmodule

// File: rtl/delay_sequencer.sv
// Delay sequencer: walks a step table, driving an action code and a
// delay-timer request per step, waiting for the timer's ready with a
// per-step timeout. All outputs are registered and aligned with the
// FSM state they describe.
module delay_sequencer
  import delay_seq_pkg::*;
#(
  parameter int          NSTEP       = 8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd3_000_000,
  parameter step_table_t TABLE       = DEFAULT_TABLE
) (
  input logic             clk,
  input logic             reset,
  delay_sequencer_if.slave bus
);

  // Count value seen on the last allowed WAIT cycle.
  localparam logic [TCNT_W-1:0] TMO_LAST = TIMEOUT_CYC - 24'd1;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q,  step_d;
  logic [ACT_W-1:0]  act_q,   act_d;
  logic [DSEL_W-1:0] x_q,     x_d;
  logic              en_q,    en_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic [TCNT_W-1:0] tcnt_q,  tcnt_d;
  step_entry_t       entry_s;

  delay_seq_rom #(
    .NSTEP (NSTEP),
    .TABLE (TABLE)
  ) u_rom (
    .idx_i   (step_q),
    .entry_o (entry_s)
  );

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    act_d   = act_q;
    x_d     = x_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;

    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d = ST_IDLE;
      act_d   = 4'd0;
      x_d     = DSEL_10MS;
      tcnt_d  = 24'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            err_d   = 1'b0;
            step_d  = 4'd0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          act_d   = entry_s.act;
          x_d     = entry_s.dsel;
          tcnt_d  = 24'd0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          tcnt_d = sat_inc(tcnt_q);
          // ready wins over a coincident timeout
          if (bus.ready_i) begin
            if (entry_s.last) begin
              state_d = ST_FIN;
            end else begin
              state_d = ST_GAP;
            end
          end else if (tcnt_q >= TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_GAP: begin
          step_d  = step_q + 4'd1;
          state_d = ST_ISSUE;
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status outputs describe the state being entered, so they line up
    // with state_q once registered.
    en_d   = (state_d == ST_WAIT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      act_q   <= 4'd0;
      x_q     <= DSEL_10MS;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      act_q   <= act_d;
      x_q     <= x_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.enable_o = en_q;
  assign bus.x_o      = x_q;
  assign bus.act_o    = act_q;
  assign bus.step_o   = step_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_delay_sequencer.sv
// Scoreboard bench for delay_sequencer. dut_a runs a two-step table,
// dut_b the default eight-step table; both use a 16-cycle timeout.
module tb_delay_sequencer;
  import delay_seq_pkg::*;

  function automatic step_table_t table_a();
    step_table_t t;
    t    = '0;
    t[0] = mk_entry(4'd1, DSEL_10MS, 1'b0);
    t[1] = mk_entry(4'd2, DSEL_2S,   1'b1);
    return t;
  endfunction

  localparam step_table_t TABLE_A = table_a();

  localparam int EV_ISSUE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_END   = 2;

  typedef struct {
    int kind;
    int act;
    int x;
    int step;
    int n;
    int err;
    int fin;
  } ev_t;

  logic clk;
  logic reset_s;
  logic start_s;
  logic abort_s;
  logic ready_s;
  logic sel_b;
  int   rdy_dly;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  logic       mon_en, mon_busy, mon_done, mon_err;
  logic [1:0] mon_x;
  logic [3:0] mon_act, mon_step;

  delay_sequencer_if if_a ();
  delay_sequencer_if if_b ();

  assign if_a.start   = start_s & ~sel_b;
  assign if_b.start   = start_s & sel_b;
  assign if_a.abort   = abort_s;
  assign if_b.abort   = abort_s;
  assign if_a.ready_i = ready_s;
  assign if_b.ready_i = ready_s;

  delay_sequencer #(.NSTEP(8), .TIMEOUT_CYC(24'd16), .TABLE(TABLE_A)) dut_a (
    .clk   (clk),
    .reset (reset_s),
    .bus   (if_a)
  );

  delay_sequencer #(.NSTEP(8), .TIMEOUT_CYC(24'd16), .TABLE(DEFAULT_TABLE)) dut_b (
    .clk   (clk),
    .reset (reset_s),
    .bus   (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Route the selected DUT to the monitor.
  always_comb begin
    if (sel_b) begin
      mon_en = if_b.enable_o; mon_x = if_b.x_o; mon_act = if_b.act_o;
      mon_step = if_b.step_o; mon_busy = if_b.busy; mon_done = if_b.done;
      mon_err = if_b.err;
    end else begin
      mon_en = if_a.enable_o; mon_x = if_a.x_o; mon_act = if_a.act_o;
      mon_step = if_a.step_o; mon_busy = if_a.busy; mon_done = if_a.done;
      mon_err = if_a.err;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", name, budget);
  endtask

  task automatic exp_issue(input int a, input int x, input int s, input int low);
    ev_t e;
    e.kind = EV_ISSUE; e.act = a; e.x = x; e.step = s; e.n = low; e.err = 0; e.fin = 0;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input int a, input int s);
    ev_t e;
    e.kind = EV_DONE; e.act = a; e.x = 0; e.step = s; e.n = 0; e.err = 0; e.fin = 0;
    exp_q.push_back(e);
  endtask

  // a < 0 means the action code is not checked at the end of the run.
  task automatic exp_end(input int er, input int a, input int whi, input int fin);
    ev_t e;
    e.kind = EV_END; e.act = a; e.x = 0; e.step = 0; e.n = whi; e.err = er; e.fin = fin;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input int a, input int x, input int s,
                      input int n, input int er, input int fin, input int en);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          EV_ISSUE: begin
            chk("issue_act", a, e.act);
            chk("issue_x", x, e.x);
            chk("issue_step", s, e.step);
            chk("issue_low_cycles", n, e.n);
          end
          EV_DONE: begin
            chk("done_act", a, e.act);
            chk("done_step", s, e.step);
          end
          default: begin
            chk("end_err", er, e.err);
            if (e.act >= 0) chk("end_act", a, e.act);
            chk("end_wait_cycles", n, e.n);
            chk("end_after_fin", fin, e.fin);
            chk("end_enable", en, 0);
          end
        endcase
      end
    end
  endtask

  // Monitor: turns output activity into events and scores them.
  initial begin
    logic prev_en, prev_busy, prev_done;
    int   low, hi;
    prev_en = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    low = 0; hi = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !prev_en) begin
        take(EV_ISSUE, int'(mon_act), int'(mon_x), int'(mon_step), low, 0, 0, 1);
        low = 0;
        hi  = 1;
      end else if (mon_en) begin
        hi++;
      end
      if (!mon_busy) low = 0;
      else if (!mon_en) low++;
      if (mon_done) begin
        take(EV_DONE, int'(mon_act), 0, int'(mon_step), 0, 0, 0, 0);
        chk("done_single_cycle", int'(prev_done), 0);
      end
      if (!mon_busy && prev_busy) begin
        take(EV_END, int'(mon_act), 0, 0, hi, int'(mon_err), int'(prev_done), int'(mon_en));
      end
      prev_en = mon_en; prev_busy = mon_busy; prev_done = mon_done;
    end
  end

  // Ready responder: ready_i during WAIT cycle number rdy_dly+1 of each step.
  initial begin
    int n;
    n = 0;
    ready_s = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) n++;
      else n = 0;
      ready_s = (mon_en && rdy_dly >= 0 && n == rdy_dly + 1);
    end
  end

  task automatic wait_busy(input logic v, input int budget);
    int n;
    n = 0;
    while (mon_busy !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mon_busy !== v) bound_fail("wait_busy", budget);
  endtask

  task automatic wait_step(input int s, input int budget);
    int n;
    n = 0;
    while (!(mon_en && int'(mon_step) == s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(mon_en && int'(mon_step) == s)) bound_fail("wait_step", budget);
  endtask

  task automatic start_pulse();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enable"}, int'(mon_en), 0);
    chk({tag, "_x"}, int'(mon_x), 0);
    chk({tag, "_act"}, int'(mon_act), 0);
    chk({tag, "_step"}, int'(mon_step), 0);
    chk({tag, "_busy"}, int'(mon_busy), 0);
    chk({tag, "_done"}, int'(mon_done), 0);
    chk({tag, "_err"}, int'(mon_err), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_s = 1'b1; start_s = 1'b0; abort_s = 1'b0; sel_b = 1'b0; rdy_dly = 5;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_s = 1'b0;
    @(negedge clk);

    // Two-step run, ready 5 cycles after each enable rise.
    rdy_dly = 5;
    exp_issue(1, 0, 0, 1);
    exp_issue(2, 1, 1, 2);
    exp_done(2, 1);
    exp_end(0, 2, 6, 1);
    start_pulse();
    wait_busy(1'b0, 200);
    repeat (2) @(negedge clk);

    // Timeout: ready never arrives.
    rdy_dly = -1;
    exp_issue(1, 0, 0, 1);
    exp_end(1, -1, 16, 0);
    start_pulse();
    wait_busy(1'b0, 200);
    repeat (2) @(negedge clk);
    chk("err_sticky", int'(mon_err), 1);
    chk("idle_enable_after_timeout", int'(mon_en), 0);

    // Ready on exactly the timeout cycle of every step.
    rdy_dly = 15;
    exp_issue(1, 0, 0, 1);
    exp_issue(2, 1, 1, 2);
    exp_done(2, 1);
    exp_end(0, 2, 16, 1);
    start_pulse();
    chk("err_clear_on_start", int'(mon_err), 0);
    wait_busy(1'b0, 200);
    repeat (2) @(negedge clk);

    // Abort on the 3rd WAIT cycle of step 1.
    rdy_dly = 5;
    exp_issue(1, 0, 0, 1);
    exp_issue(2, 1, 1, 2);
    exp_end(0, 0, 3, 0);
    start_pulse();
    wait_step(1, 100);
    repeat (2) @(negedge clk);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    chk("abort_busy", int'(mon_busy), 0);
    chk("abort_act", int'(mon_act), 0);
    chk("abort_enable", int'(mon_en), 0);
    chk("abort_err", int'(mon_err), 0);
    chk("abort_done", int'(mon_done), 0);
    repeat (2) @(negedge clk);

    // start held high: exactly two back-to-back runs.
    rdy_dly = 0;
    for (int r = 0; r < 2; r++) begin
      exp_issue(1, 0, 0, 1);
      exp_issue(2, 1, 1, 2);
      exp_done(2, 1);
      exp_end(0, 2, 1, 1);
    end
    start_s = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 100);
    @(negedge clk);
    chk("restart_after_idle", int'(mon_busy), 1);
    wait_busy(1'b0, 100);
    start_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_third_run", int'(mon_busy), 0);

    // Default table: reset during WAIT of step 3, then a full fresh run.
    sel_b = 1'b1;
    rdy_dly = 2;
    @(negedge clk);
    exp_issue(1, 0, 0, 1);
    exp_issue(2, 1, 1, 2);
    exp_issue(3, 0, 2, 2);
    exp_issue(4, 1, 3, 2);
    exp_end(0, 0, 2, 0);
    start_pulse();
    wait_step(3, 200);
    @(negedge clk);
    reset_s = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    reset_s = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_issue(i + 1, i % 2, i, (i == 0) ? 1 : 2);
    end
    exp_done(8, 7);
    exp_end(0, 8, 3, 1);
    start_pulse();
    wait_busy(1'b0, 400);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_sequencer.md
DELAY_SEQUENCER -- requirements
Module: delay_sequencer

Interface
REQ-001 Parameter NSTEP, default 8: number of entries in the step table (max 16).
REQ-002 Parameter TIMEOUT_CYC, default 24'd3_000_000: clk cycles allowed per step for ready_i before error.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level-sampled request to run the step table from step 0.
REQ-006 abort  input  1  synchronous abort of a running sequence.
REQ-007 ready_i  input  1  delay-elapsed indication from the downstream delay-timer stage.
REQ-008 enable_o  output  1  delay-timer enable; held high while a step's delay is pending.
REQ-009 x_o  output  2  delay-length select to the delay timer; 00=10 ms, 01=2 s, 10/11 reserved.
REQ-010 act_o  output  4  action code of the current step, driven to the controlled device.
REQ-011 step_o  output  4  index of the current step.
REQ-012 busy  output  1  high from leaving IDLE until returning to IDLE.
REQ-013 done  output  1  one-cycle pulse on successful completion of the last step.
REQ-014 err  output  1  sticky timeout flag; cleared by the next accepted start or by reset.

Function
REQ-015 Each step table entry SHALL hold {act[3:0], dsel[1:0], last[0]}; the sequence SHALL end at the first entry with last=1, or at entry NSTEP-1 if no entry sets last.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, GAP, FIN.
REQ-017 IDLE: on start=1, the block SHALL clear err and step_o, then go to ISSUE on the next cycle; start SHALL be ignored in every state other than IDLE.
REQ-018 ISSUE (1 cycle): the block SHALL load act_o and x_o from the current entry, clear the timeout counter, and go to WAIT; enable_o SHALL stay low.
REQ-019 WAIT: enable_o SHALL be 1 and x_o stable; the timeout counter SHALL increment each cycle.
REQ-020 When ready_i=1 in WAIT, the block SHALL enter GAP on the next cycle; if last, it SHALL enter FIN instead.
REQ-021 GAP (exactly 1 cycle): enable_o SHALL be 0 so the downstream counter clears; step_o SHALL then increment, followed by ISSUE.
REQ-022 FIN (1 cycle): done SHALL pulse, enable_o SHALL be 0, then the block SHALL return to IDLE; act_o SHALL hold the last step's code.
REQ-023 Timeout: if the counter reaches TIMEOUT_CYC-1 in WAIT with ready_i=0, err SHALL be set, enable_o cleared and the FSM returned to IDLE; done SHALL NOT pulse.
REQ-024 If ready_i and timeout occur in the same cycle, ready_i SHALL win and no error is flagged.
REQ-025 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle with enable_o=0 and act_o=0, without done or err.
REQ-026 abort SHALL take priority over ready_i and timeout in the same cycle.
REQ-027 ready_i SHALL be ignored outside WAIT.
REQ-028 Minimum per-step overhead SHALL be 3 cycles (ISSUE, ready-detect, GAP) beyond the delay itself.
REQ-029 The timeout counter SHALL be 24 bits wide and saturate; it SHALL never wrap.

Reset
REQ-030 reset=1 at a clk edge SHALL force IDLE, enable_o=0, x_o=00, act_o=0, step_o=0, busy=0, done=0, err=0 and clear the timeout counter, including mid-sequence.

Structure
REQ-031 The step-entry field widths, the state encoding, the DSEL_10MS/DSEL_2S codes and the default step table SHALL live in a shared package, delay_seq_pkg.
REQ-032 The step table SHALL be a sub-module, delay_seq_rom: a combinational lookup by step index, replaceable per product.

Verification
REQ-033 Table {A=1,dsel=00},{A=2,dsel=01,last}, with ready_i asserted 5 cycles after each enable_o rise -> act_o 1 then 2, one GAP low cycle between steps, done pulse, busy falls the cycle after FIN.
REQ-034 TIMEOUT_CYC=16, ready_i never asserted -> err=1 after 16 WAIT cycles, enable_o=0, FSM in IDLE, no done pulse.
REQ-035 abort asserted on the 3rd WAIT cycle of step 1 -> IDLE next cycle, act_o=0, enable_o=0, err=0, done=0.
REQ-036 ready_i=1 on exactly the timeout cycle -> step advances and err stays 0.
REQ-037 reset asserted mid-WAIT of step 3 -> all outputs at their reset values the next cycle; a subsequent start runs again from step 0.
REQ-038 start held high through a full run -> the sequence restarts only after returning to IDLE, and each run produces exactly one done pulse.
